sobel_mult_seq: RTL and testbench
=================================

# sobel_mult_seq

Parametrised multi-cycle multiplier custom instruction for the Sobel datapath. It is the sequential successor to the combinational Sobel multiply, and keeps its single-cycle fast path for kernel weights 0, 1 and 2. It also handles arbitrary operands with an early-terminating shift-add engine and selectable signedness, and returns either half of the full product. It sits on the processor's multicycle custom-instruction port, with a start/done handshake and clock enable.

## Interface
- WIDTH, 32, operand and result width in bits (≥4).
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  when 0, all state/registers hold.
- start  in  1  request; sampled only in IDLE with clk_en=1.
- n  in  1  0 = low WIDTH bits of product; 1 = high WIDTH bits of the 2·WIDTH product.
- dataa  in  WIDTH  multiplicand.
- datab  in  WIDTH  multiplier.
- result  out  WIDTH  product half selected by n; registered.
- done  out  1  one-cycle pulse marking valid result.

## Operation
- Reset: state IDLE, done=0, result=0, all internal registers 0. Reset mid-operation aborts with no done pulse.
- Magnitudes: |x| = x when SIGNED=0. When SIGNED=1 and x is negative, |x| = −x as a WIDTH-bit unsigned value (most-negative maps to 2^(WIDTH−1)). Product sign is the XOR of the operand MSBs when SIGNED=1, otherwise positive.
- At the start edge E0, n, the sign and both magnitudes are latched.
- Fast path: |a| or |b| ∈ {0,1,2}. The result is formed directly (0, the other magnitude, or the other magnitude <<1, at 2·WIDTH), sign-corrected, n-selected, and registered at E0 with done=1. FSM stays IDLE.
- General path: state CALC. Each clk_en edge examines the multiplier LSB. If it is 1, the shifted multiplicand is added into the 2·WIDTH accumulator. Then the multiplicand shifts left by 1 and the multiplier shifts right by 1.
- CALC ends on the edge where the shifted multiplier becomes 0. That same edge registers result = n-selected half of the (negated if needed) accumulator-next value, sets done=1, and returns to IDLE.
- States: IDLE →(start, fast) IDLE + done. IDLE →(start, general) CALC. CALC →(multiplier-next == 0) IDLE + done. Otherwise CALC persists.
- done is cleared on the next clk_en edge. result holds until the next accepted start's completion.
- start while in CALC is ignored, and not queued. start coinciding with reset: reset wins.
- Product arithmetic is exact at 2·WIDTH, with no overflow flag. The n=0 result is identical for SIGNED=0/1.

## Timing
- Latency L = edges from E0 until done is first sampled high, counting clk_en=1 edges only.
- Fast path: L=1.
- General: L = k+1, where k = bit length of |b| (2 ≤ k ≤ WIDTH). Maximum L = WIDTH+1.
- clk_en=0 cycles stretch latency one-for-one; done stays high through them.
- A back-to-back start is accepted on the same edge done is cleared (the cycle done is high, state is IDLE).

## Structure
- Package sobel_pkg: state enum (IDLE, CALC), default WIDTH constant, and fast-path weight constants 0/1/2.
- Sub-module mult_shift_add_core holds the accumulator, shifted multiplicand/multiplier registers and the next-value adder. The top holds the FSM, magnitude/sign logic, fast path and result select.

## Test plan
- SIGNED=0, a=7, b=2, n=0 → result 14, L=1. Then a=2, b=0x9 → 18, L=1.
- SIGNED=0, a=3, b=5, n=0 → result 15, done at L=4, single-cycle pulse, result held 10 cycles after.
- SIGNED=0, WIDTH=32, a=b=0xFFFFFFFF → n=0 gives 0x00000001 and n=1 gives 0xFFFFFFFE, L=33.
- SIGNED=1, a=0xFFFFFFFD (−3), b=5 → n=0 gives 0xFFFFFFF1 and n=1 gives 0xFFFFFFFF, L=4. Also a=0x80000000, b=0xFFFFFFFF (−1), n=1 → 0x00000000, n=0 → 0x80000000.
- a=3, b=0xFF: pulse start again at cycle 3 (ignored) and hold clk_en=0 for 5 cycles mid-CALC → one done only, 765, L=9 plus 5 stall cycles.
- Assert reset during CALC of a=3, b=0xFF → done=0, result=0 next cycle, no later done. A subsequent a=6, b=7 → 42, L=4.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM states, default operand width and Sobel kernel weights
package sobel_pkg;
    typedef enum logic {IDLE, CALC} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int W_ZERO = 0;
    localparam int W_ONE  = 1;
    localparam int W_TWO  = 2;
endpackage

// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core: shift-add datapath with 2*WIDTH accumulator and early-out multiplier view
module mult_shift_add_core
    import sobel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplr,
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic [WIDTH-1:0]   o_mplr_next
);
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplr;

    assign o_acc_next  = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign o_mplr_next = r_mplr >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mcand <= (2*WIDTH)'(i_mcand);
            r_mplr  <= i_mplr;
        end else if (i_step) begin
            r_acc   <= o_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= o_mplr_next;
        end
    end
endmodule

// File: rtl/sobel_mult_seq.sv
// sobel_mult_seq: multi-cycle multiplier custom instruction with 0/1/2 single-cycle fast path
module sobel_mult_seq
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic             n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    localparam int PW = 2 * WIDTH;
    state_t           r_state, w_state_next;
    logic             r_done, r_n, r_sign;
    logic [WIDTH-1:0] r_result, w_mag_a, w_mag_b, w_mplr_next, w_fast_res, w_calc_res;
    logic [PW-1:0]    w_ext_a, w_ext_b, w_fast_prod, w_fast_signed, w_acc_next, w_calc_signed;
    logic             w_sign, w_fast, w_go, w_step, w_calc_end;

    assign w_mag_a = (SIGNED && dataa[WIDTH-1]) ? -dataa : dataa;
    assign w_mag_b = (SIGNED && datab[WIDTH-1]) ? -datab : datab;
    assign w_sign  = SIGNED && (dataa[WIDTH-1] ^ datab[WIDTH-1]);
    assign w_ext_a = PW'(w_mag_a);
    assign w_ext_b = PW'(w_mag_b);
    assign w_fast  = (w_mag_a <= WIDTH'(W_TWO)) || (w_mag_b <= WIDTH'(W_TWO));
    // One magnitude is a kernel weight, so the product is a select/shift of the other
    assign w_fast_prod = (w_mag_a == WIDTH'(W_ZERO) || w_mag_b == WIDTH'(W_ZERO)) ? '0 :
                         (w_mag_a == WIDTH'(W_ONE)) ? w_ext_b :
                         (w_mag_a == WIDTH'(W_TWO)) ? w_ext_b << 1 :
                         (w_mag_b == WIDTH'(W_ONE)) ? w_ext_a : w_ext_a << 1;
    assign w_fast_signed = w_sign ? -w_fast_prod : w_fast_prod;
    assign w_fast_res    = n ? w_fast_signed[PW-1:WIDTH] : w_fast_signed[WIDTH-1:0];

    assign w_go          = clk_en && start && r_state == IDLE;
    assign w_step        = clk_en && r_state == CALC;
    assign w_calc_end    = w_step && w_mplr_next == '0;
    assign w_calc_signed = r_sign ? -w_acc_next : w_acc_next;
    assign w_calc_res    = r_n ? w_calc_signed[PW-1:WIDTH] : w_calc_signed[WIDTH-1:0];

    mult_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_go && !w_fast),
        .i_step      (w_step),
        .i_mcand     (w_mag_a),
        .i_mplr      (w_mag_b),
        .o_acc_next  (w_acc_next),
        .o_mplr_next (w_mplr_next)
    );

    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE)
            w_state_next = (start && !w_fast) ? CALC : IDLE;
        else
            w_state_next = (w_mplr_next == '0) ? IDLE : CALC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_sign   <= 1'b0;
        end else if (clk_en) begin
            r_state <= w_state_next;
            r_done  <= (w_go && w_fast) || w_calc_end;
            if (w_go && w_fast)
                r_result <= w_fast_res;
            else if (w_calc_end)
                r_result <= w_calc_res;
            if (w_go) begin
                r_n    <= n;
                r_sign <= w_sign;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
endmodule

// File: tb/tb_sobel_mult_seq.sv
// tb_sobel_mult_seq: directed and random checks of unsigned and signed instances against an arithmetic model
module tb_sobel_mult_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        n = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result0, result1;
    logic        done0, done1;
    int          checks = 0;
    int          failures = 0;

    sobel_mult_seq #(.WIDTH(32), .SIGNED(1'b0)) u_uns (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start0), .n(n),
        .dataa(dataa), .datab(datab), .result(result0), .done(done0)
    );
    sobel_mult_seq #(.WIDTH(32), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start1), .n(n),
        .dataa(dataa), .datab(datab), .result(result1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full product from plain arithmetic; latency from the bit length of |b|
    task automatic op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit nn, input string tag);
        logic [63:0] p;
        logic [31:0] ma, mb, t, r;
        int k, lat, exp_l;
        bit got;
        if (s) begin
            ma = a[31] ? 32'(0 - a) : a;
            mb = b[31] ? 32'(0 - b) : b;
            p  = 64'(longint'($signed(a)) * longint'($signed(b)));
        end else begin
            ma = a;
            mb = b;
            p  = {32'h0, a} * {32'h0, b};
        end
        k = 0;
        t = mb;
        while (t != 0) begin
            k++;
            t = t >> 1;
        end
        exp_l = (ma <= 2 || mb <= 2) ? 1 : k + 1;
        @(negedge clk);
        dataa = a;
        datab = b;
        n = nn;
        start0 = !s;
        start1 = s;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            start0 = 0;
            start1 = 0;
            dataa = $urandom;
            datab = $urandom;
            n = 1'($urandom);
            got = s ? done1 : done0;
        end
        r = s ? result1 : result0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_l));
        chk({tag, "_res"}, 64'(r), 64'(nn ? p[63:32] : p[31:0]));
        tick();
        chk({tag, "_pulse"}, 64'(s ? done1 : done0), 64'd0);
    endtask

    initial begin
        int first, cnt;
        bit prev, seen;
        logic [31:0] ra, rb;
        repeat (3) tick();
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_res0", 64'(result0), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        chk("rst_res1", 64'(result1), 64'd0);
        @(negedge clk);
        reset = 0;

        op(0, 32'd7, 32'd2, 0, "fast_7x2");
        op(0, 32'd2, 32'h9, 0, "fast_2x9");
        op(0, 32'd3, 32'd5, 0, "gen_3x5");
        repeat (10) tick();
        chk("hold_3x5", 64'(result0), 64'd15);
        op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "max_lo");
        op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "max_hi");
        op(1, 32'hFFFFFFFD, 32'd5, 0, "s_m3x5_lo");
        op(1, 32'hFFFFFFFD, 32'd5, 1, "s_m3x5_hi");
        op(1, 32'h80000000, 32'hFFFFFFFF, 1, "s_min_hi");
        op(1, 32'h80000000, 32'hFFFFFFFF, 0, "s_min_lo");
        op(1, 32'hFFFFFFFE, 32'h7, 0, "s_m2x7");

        // Ignored restart on edge 3 and a five-edge clk_en stall mid-CALC
        @(negedge clk);
        dataa = 32'd3;
        datab = 32'hFF;
        n = 0;
        start0 = 1;
        first = 0;
        cnt = 0;
        prev = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done0 && !prev) begin
                cnt++;
                if (first == 0) first = i;
            end
            prev = done0;
            start0 = (i == 2);
            clk_en = !(i >= 4 && i <= 8);
        end
        chk("stall_count", 64'(cnt), 64'd1);
        chk("stall_lat", 64'(first), 64'd14);
        chk("stall_res", 64'(result0), 64'd765);

        // Reset mid-CALC aborts without a done pulse
        @(negedge clk);
        dataa = 32'd3;
        datab = 32'hFF;
        start0 = 1;
        tick();
        start0 = 0;
        tick();
        tick();
        reset = 1;
        tick();
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_res", 64'(result0), 64'd0);
        reset = 0;
        seen = 0;
        repeat (20) begin
            tick();
            if (done0) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        op(0, 32'd6, 32'd7, 0, "after_abort");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = -rb;
            op(1'($urandom), ra, rb, 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
